// File: rtl/gticc_pkg.sv
// Shared constants and types for the GTICC 8b/10b framing path (TX framer and RX deframer).
package gticc_pkg;

  localparam logic [7:0]  K28_5     = 8'hBC;
  localparam logic [7:0]  K27_7     = 8'hFB;
  localparam logic [7:0]  K29_7     = 8'hFD;
  localparam logic [31:0] IDLE_WORD = 32'h5050_50BC;
  localparam logic [3:0]  K_BYTE0   = 4'b0001;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_IDLE,
    ST_SOF,
    ST_DATA,
    ST_EOF
  } gticc_state_t;

  typedef enum logic [1:0] {
    SEL_IDLE,
    SEL_SOF,
    SEL_DATA,
    SEL_EOF
  } gticc_sel_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  charisk;
  } gticc_word_t;

  // K character always lands in byte0 so the RX comma aligner locks on lane 0.
  function automatic gticc_word_t gticc_ctrl(input logic [7:0] k, input logic [7:0] seq,
                                             input logic flag);
    gticc_word_t w;
    w.data    = {7'h0, flag, 8'h0, seq, k};
    w.charisk = K_BYTE0;
    return w;
  endfunction

endpackage

// File: rtl/gticc_txframer_if.sv
// Payload stream into the TX framer: valid/ready handshake with end-of-frame marker.
interface gticc_txframer_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;

  modport master (output s_data, s_valid, s_last, input s_ready);
  modport slave  (input s_data, s_valid, s_last, output s_ready);
endinterface

// File: rtl/gticc_txframer_mux.sv
// Registered TXDATA/TXCHARISK selector; one cycle behind the select that picks the word.
module gticc_txframer_mux
  import gticc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  gticc_sel_t  i_sel,
  input  logic [31:0] i_data,
  input  logic [7:0]  i_seq,
  input  logic        i_trunc,
  output logic [31:0] o_txdata,
  output logic [3:0]  o_txcharisk
);

  gticc_word_t w_word;
  gticc_word_t r_word;

  always_comb begin
    w_word = '{data: IDLE_WORD, charisk: K_BYTE0};
    unique case (i_sel)
      SEL_SOF:  w_word = gticc_ctrl(K27_7, i_seq, 1'b0);
      SEL_EOF:  w_word = gticc_ctrl(K29_7, i_seq, i_trunc);
      SEL_DATA: w_word = '{data: i_data, charisk: 4'b0000};
      default:  w_word = '{data: IDLE_WORD, charisk: K_BYTE0};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_word <= '{data: IDLE_WORD, charisk: K_BYTE0};
    else        r_word <= w_word;
  end

  assign o_txdata    = r_word.data;
  assign o_txcharisk = r_word.charisk;

endmodule

// File: rtl/gticc_txframer.sv
// GTICC TX framer: wraps payload into SOF/DATA/EOF words with periodic IDLE for comma alignment.
module gticc_txframer
  import gticc_pkg::*;
#(
  parameter int ALIGN_INTERVAL = 1024,
  parameter int MAX_WORDS      = 256
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                link_en,
  gticc_txframer_if.slave     s,
  output logic [31:0]         TXDATA,
  output logic [3:0]          TXCHARISK,
  output logic [15:0]         frame_cnt,
  output logic                abort,
  output logic                trunc
);

  localparam int AW = (ALIGN_INTERVAL > 2) ? $clog2(ALIGN_INTERVAL) : 2;
  localparam int WW = $clog2(MAX_WORDS + 1);
  localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_INTERVAL - 1);
  localparam logic [WW-1:0] WORD_LAST  = WW'(MAX_WORDS - 1);

  logic [1:0]   r_rst_sync;
  logic         w_rst_n;
  gticc_state_t r_state, w_next;
  gticc_sel_t   w_sel;
  logic         w_ready, w_acc, w_abort, w_trunc, w_done, w_align_due;
  logic [7:0]   r_seq;
  logic [15:0]  r_frame_cnt;
  logic [AW-1:0] r_align;
  logic [WW-1:0] r_wcnt;
  logic         r_trunc_flag, r_drain, r_abort, r_trunc;

  // Assert asynchronously, release on a clock edge so no flop sees a runt deassert.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_rst_sync <= 2'b00;
    else       r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_align_due = (r_align >= ALIGN_LAST);
  assign w_acc       = w_ready & s.s_valid;

  always_comb begin
    w_next  = r_state;
    w_sel   = SEL_IDLE;
    w_ready = 1'b0;
    w_abort = 1'b0;
    w_trunc = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      ST_OFF: begin
        if (link_en) w_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (!link_en)       w_next = ST_OFF;
        else if (r_drain)   w_ready = 1'b1;   // swallow the tail of a truncated frame
        else if (s.s_valid) w_next = ST_SOF;
      end
      ST_SOF: begin
        if (!link_en) begin
          w_next  = ST_OFF;
          w_abort = 1'b1;
        end else begin
          w_sel  = SEL_SOF;
          w_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!link_en) begin
          w_next  = ST_OFF;
          w_abort = 1'b1;
        end else if (!w_align_due) begin
          w_ready = 1'b1;
          if (s.s_valid) begin
            w_sel = SEL_DATA;
            if (s.s_last) begin
              w_next = ST_EOF;
            end else if (r_wcnt == WORD_LAST) begin
              w_next  = ST_EOF;
              w_trunc = 1'b1;
            end
          end
        end
      end
      ST_EOF: begin
        if (!link_en) begin
          w_next  = ST_OFF;
          w_abort = 1'b1;
        end else if (!w_align_due) begin
          // EOF waits behind a due IDLE so it never stretches the gap past the interval.
          w_sel  = SEL_EOF;
          w_next = ST_IDLE;
          w_done = 1'b1;
        end
      end
      default: w_next = ST_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_OFF;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_seq        <= '0;
      r_frame_cnt  <= '0;
      r_align      <= '0;
      r_wcnt       <= '0;
      r_trunc_flag <= 1'b0;
      r_drain      <= 1'b0;
      r_abort      <= 1'b0;
      r_trunc      <= 1'b0;
    end else begin
      r_abort <= w_abort;
      r_trunc <= w_trunc;
      r_align <= (w_sel == SEL_IDLE) ? '0 : r_align + 1'b1;

      if (r_state == ST_SOF)                 r_wcnt <= '0;
      else if (w_acc && r_state == ST_DATA)  r_wcnt <= r_wcnt + 1'b1;

      if (r_state == ST_SOF) r_trunc_flag <= 1'b0;
      else if (w_trunc)      r_trunc_flag <= 1'b1;

      // Link loss flushes drain so a fresh frame after reconnect is not eaten.
      if (r_state == ST_OFF)                                 r_drain <= 1'b0;
      else if (w_trunc)                                      r_drain <= 1'b1;
      else if (r_state == ST_IDLE && w_acc && s.s_last)      r_drain <= 1'b0;

      if (w_done) begin
        r_seq       <= r_seq + 8'd1;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  gticc_txframer_mux u_mux (
    .clk         (clk),
    .rst_n       (w_rst_n),
    .i_sel       (w_sel),
    .i_data      (s.s_data),
    .i_seq       (r_seq),
    .i_trunc     (r_trunc_flag),
    .o_txdata    (TXDATA),
    .o_txcharisk (TXCHARISK)
  );

  assign s.s_ready = w_ready;
  assign frame_cnt = r_frame_cnt;
  assign abort     = r_abort;
  assign trunc     = r_trunc;

endmodule

// File: tb/tb_gticc_txframer.sv
// Bench for gticc_txframer: directed frames plus random traffic parsed against a frame-level model.
module tb_gticc_txframer;

  localparam int AI     = 8;
  localparam int MW     = 24;
  localparam int BUDGET = 64;
  localparam logic [31:0] IDLE_W = 32'h5050_50BC;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        link_en = 1'b0;
  logic [31:0] txd;
  logic [3:0]  txk;
  logic [15:0] fcnt;
  logic        abort_o, trunc_o;

  gticc_txframer_if sif ();

  gticc_txframer #(.ALIGN_INTERVAL(AI), .MAX_WORDS(MW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .link_en   (link_en),
    .s         (sif),
    .TXDATA    (txd),
    .TXCHARISK (txk),
    .frame_cnt (fcnt),
    .abort     (abort_o),
    .trunc     (trunc_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        mon_en = 1'b0;
  logic [35:0] tx_q[$];
  int          abort_seen = 0;
  int          trunc_seen = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      tx_q.push_back({txk, txd});
      if (abort_o) abort_seen++;
      if (trunc_o) trunc_seen++;
    end
  end

  // Frame-level reference model
  int          m_seq = 0;
  int          m_fcnt = 0;
  int          exp_len[$];
  bit          exp_tr[$];
  bit          exp_ab[$];
  int          exp_seq[$];
  logic [31:0] exp_pay[$];
  logic [31:0] cur_w[$];

  int          p_fi = 0;
  int          p_pp = 0;
  logic [31:0] p_got[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_word();
    logic [31:0] w;
    logic [7:0]  b;
    b = 8'($urandom);
    case ($urandom_range(0, 7))
      0:       w = IDLE_W;
      1:       w = {16'h0, b, 8'hFB};
      2:       w = {16'h0, b, 8'hFD};
      default: w = $urandom;
    endcase
    return w;
  endfunction

  // mode 0: back-to-back, 1: random gaps, 2: two idle cycles before word 1
  task automatic send_frame(input int n, input int mode, input int drop_after);
    logic [31:0] w;
    bit got;
    int c;
    int acc_n;
    bit dropped;
    acc_n = 0;
    dropped = 1'b0;
    cur_w.delete();
    for (int i = 0; i < n; i++) begin
      w = pick_word();
      if (mode == 1) begin
        while ($urandom_range(0, 99) < 25) begin
          sif.s_valid = 1'b0;
          sif.s_last  = 1'($urandom_range(0, 1));
          cyc(1);
        end
      end
      if (mode == 2 && i == 1) begin
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b1;
        cyc(2);
      end
      sif.s_data  = w;
      sif.s_last  = (i == n - 1);
      sif.s_valid = 1'b1;
      got = 1'b0;
      c = 0;
      while (!got && c < BUDGET) begin
        @(negedge clk);
        got = sif.s_ready;
        @(posedge clk);
        #1;
        c++;
      end
      if (!got) begin
        chk("accept_timeout", 64'(got), 64'd1);
        break;
      end
      acc_n++;
      cur_w.push_back(w);
      if (i < MW) exp_pay.push_back(w);
      if (i == drop_after) begin
        link_en = 1'b0;
        dropped = 1'b1;
        break;
      end
    end
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    exp_len.push_back(acc_n < MW ? acc_n : MW);
    exp_tr.push_back(!dropped && n > MW);
    exp_ab.push_back(dropped);
    exp_seq.push_back(m_seq);
    if (!dropped) begin
      m_seq  = (m_seq + 1) % 256;
      m_fcnt = m_fcnt + 1;
    end
  endtask

  task automatic check_exact(input string tag, input int start, input bit gap2, input logic [7:0] seq);
    logic [35:0] e[$];
    logic [35:0] o;
    int idx;
    idx = -1;
    e.push_back({4'b0001, IDLE_W});
    e.push_back({4'b0001, 16'h0, seq, 8'hFB});
    for (int j = 0; j < cur_w.size(); j++) begin
      if (gap2 && j == 1) begin
        e.push_back({4'b0001, IDLE_W});
        e.push_back({4'b0001, IDLE_W});
      end
      e.push_back({4'b0000, cur_w[j]});
    end
    e.push_back({4'b0001, 7'h0, 1'b0, 8'h0, seq, 8'hFD});
    e.push_back({4'b0001, IDLE_W});
    for (int i = start; i < tx_q.size(); i++)
      if (idx < 0 && tx_q[i][35:32] == 4'b0001 && tx_q[i][7:0] == 8'hFB) idx = i;
    chk({tag, "_sof_found"}, 64'(idx >= 1), 64'd1);
    if (idx >= 1) begin
      for (int j = 0; j < e.size(); j++) begin
        o = 'x;
        if (idx - 1 + j < tx_q.size()) o = tx_q[idx - 1 + j];
        chk($sformatf("%s_w%0d", tag, j), 64'(o), 64'(e[j]));
      end
    end
  endtask

  task automatic close_frame(input bit ab, input logic [7:0] sseq, input logic [7:0] eseq, input bit tr);
    logic [31:0] o;
    if (p_fi >= exp_ab.size()) begin
      chk("extra_frame", 64'(p_fi), 64'(exp_ab.size()));
      return;
    end
    chk($sformatf("f%0d_abort", p_fi), 64'(ab), 64'(exp_ab[p_fi]));
    chk($sformatf("f%0d_sof_seq", p_fi), 64'(sseq), 64'(exp_seq[p_fi] % 256));
    if (!ab) begin
      chk($sformatf("f%0d_eof_seq", p_fi), 64'(eseq), 64'(exp_seq[p_fi] % 256));
      chk($sformatf("f%0d_trunc_flag", p_fi), 64'(tr), 64'(exp_tr[p_fi]));
    end
    chk($sformatf("f%0d_len", p_fi), 64'(p_got.size()), 64'(exp_len[p_fi]));
    for (int j = 0; j < exp_len[p_fi]; j++) begin
      o = 'x;
      if (j < p_got.size()) o = p_got[j];
      chk($sformatf("f%0d_d%0d", p_fi, j), 64'(o), 64'(exp_pay[p_pp + j]));
    end
    p_pp = p_pp + exp_len[p_fi];
    p_fi++;
  endtask

  task automatic parse_check();
    int run, maxrun, stray, n_ab, n_tr;
    bit in_fr;
    logic [7:0] sseq;
    logic [3:0] k;
    logic [31:0] d;
    run = 0; maxrun = 0; stray = 0; n_ab = 0; n_tr = 0;
    in_fr = 1'b0;
    sseq = '0;
    p_fi = 0; p_pp = 0;
    p_got.delete();
    for (int i = 0; i < tx_q.size(); i++) begin
      k = tx_q[i][35:32];
      d = tx_q[i][31:0];
      if (k == 4'b0001 && d == IDLE_W) run = 0;
      else begin
        run++;
        if (run > maxrun) maxrun = run;
      end
      if (k == 4'b0000) begin
        if (in_fr) p_got.push_back(d);
        else stray++;
      end else if (k == 4'b0001 && d[7:0] == 8'hFB) begin
        if (in_fr) close_frame(1'b1, sseq, 8'h0, 1'b0);
        if (d[31:16] != 16'h0) stray++;
        in_fr = 1'b1;
        sseq = d[15:8];
        p_got.delete();
      end else if (k == 4'b0001 && d[7:0] == 8'hFD) begin
        if (in_fr) close_frame(1'b0, sseq, d[15:8], d[24]);
        else stray++;
        if (d[31:25] != 7'h0 || d[23:16] != 8'h0) stray++;
        in_fr = 1'b0;
      end else if (!(k == 4'b0001 && d == IDLE_W)) begin
        stray++;
      end
    end
    if (in_fr) close_frame(1'b1, sseq, 8'h0, 1'b0);
    for (int i = 0; i < exp_ab.size(); i++) begin
      if (exp_ab[i]) n_ab++;
      if (exp_tr[i]) n_tr++;
    end
    chk("frames_seen", 64'(p_fi), 64'(exp_ab.size()));
    chk("align_window", 64'(maxrun <= AI - 1), 64'd1);
    chk("stray_words", 64'(stray), 64'd0);
    chk("abort_pulses", 64'(abort_seen), 64'(n_ab));
    chk("trunc_pulses", 64'(trunc_seen), 64'(n_tr));
  endtask

  initial begin
    int st, cnt0;
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    sif.s_data  = '0;

    #12;
    chk("rst_txdata",  64'(txd), 64'(IDLE_W));
    chk("rst_charisk", 64'(txk), 64'd1);
    chk("rst_ready",   64'(sif.s_ready), 64'd0);
    chk("rst_abort",   64'(abort_o), 64'd0);
    chk("rst_trunc",   64'(trunc_o), 64'd0);
    chk("rst_fcnt",    64'(fcnt), 64'd0);

    @(posedge clk);
    #1 rstn = 1'b1;
    cyc(4);
    chk("off_txdata", 64'(txd), 64'(IDLE_W));
    chk("off_ready",  64'(sif.s_ready), 64'd0);
    mon_en  = 1'b1;
    link_en = 1'b1;
    cyc(4);

    st = tx_q.size();
    send_frame(3, 0, -1);
    cyc(5);
    check_exact("frame3", st, 1'b0, 8'd0);
    chk("fcnt_frame3", 64'(fcnt), 64'(m_fcnt));

    st = tx_q.size();
    send_frame(3, 2, -1);
    cyc(5);
    check_exact("gap2", st, 1'b1, 8'd1);
    chk("fcnt_gap2", 64'(fcnt), 64'(m_fcnt));

    send_frame(20, 0, -1);
    cyc(5);
    chk("fcnt_long", 64'(fcnt), 64'(m_fcnt));

    cnt0 = trunc_seen;
    send_frame(MW + 2, 0, -1);
    cyc(5);
    chk("trunc_pulse", 64'(trunc_seen - cnt0), 64'd1);
    chk("fcnt_trunc", 64'(fcnt), 64'(m_fcnt));

    cnt0 = abort_seen;
    st = m_fcnt;
    send_frame(5, 0, 1);
    cyc(6);
    chk("abort_pulse", 64'(abort_seen - cnt0), 64'd1);
    chk("fcnt_abort", 64'(fcnt), 64'(st));
    link_en = 1'b1;
    cyc(4);
    send_frame(3, 0, -1);
    cyc(5);

    for (int f = 0; f < 25; f++) begin
      send_frame($urandom_range(1, 30), 1, -1);
      cyc($urandom_range(0, 3));
    end
    cyc(10);
    chk("fcnt_random", 64'(fcnt), 64'(m_fcnt));
    mon_en = 1'b0;
    parse_check();

    sif.s_data  = $urandom;
    sif.s_valid = 1'b1;
    sif.s_last  = 1'b0;
    cyc(5);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_txdata",  64'(txd), 64'(IDLE_W));
    chk("mid_rst_charisk", 64'(txk), 64'd1);
    chk("mid_rst_ready",   64'(sif.s_ready), 64'd0);
    chk("mid_rst_abort",   64'(abort_o), 64'd0);
    chk("mid_rst_trunc",   64'(trunc_o), 64'd0);
    chk("mid_rst_fcnt",    64'(fcnt), 64'd0);
    sif.s_valid = 1'b0;
    cyc(3);
    rstn = 1'b1;
    cyc(5);
    chk("post_rst_fcnt", 64'(fcnt), 64'd0);

    tx_q.delete();
    mon_en = 1'b1;
    m_seq  = 0;
    m_fcnt = 0;
    cyc(2);
    st = tx_q.size();
    send_frame(2, 0, -1);
    cyc(5);
    check_exact("post_rst", st, 1'b0, 8'd0);
    chk("post_rst_fcnt1", 64'(fcnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
